fifo_axis_reader: RTL and testbench
===================================

# fifo_axis_reader

Read-side adapter that drains the Ethernet FIFO read port into an AXI-Stream master interface toward the downstream MAC/consumer. It issues FIFO reads, absorbs the one-cycle registered read latency of the FIFO block RAM, and buffers words in a 2-entry output skid buffer so that `m_axis_tready` back-pressure never loses data. Each FIFO word carries `DATA_WIDTH` payload bits plus one `tlast` flag bit. It sits entirely in the FIFO read clock domain.

## Interface
- `DATA_WIDTH`, 8, payload width; FIFO word width is `DATA_WIDTH+1`.

- `clk`  in  1  read-domain clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fifo_rd_data`  in  DATA_WIDTH+1  FIFO read data; bit `[DATA_WIDTH]` = tlast, `[DATA_WIDTH-1:0]` = payload.
- `fifo_empty`  in  1  FIFO empty flag, read-domain.
- `fifo_rd_en`  out  1  FIFO read strobe; one word popped per high cycle.
- `m_axis_tdata`  out  DATA_WIDTH  stream payload.
- `m_axis_tlast`  out  1  last byte of frame.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `frame_count`  out  16  count of completed frames (tlast handshakes), wraps.
- `in_frame`  out  1  high between first accepted byte of a frame and its tlast handshake.

## Operation
- State: `count` (0..2 words held in skid buffer), `inflight` (1 bit, read issued last cycle), buffer entries `buf0` (head, drives outputs) and `buf1`.
- `pop` = `m_axis_tvalid & m_axis_tready`.
- `fifo_rd_en` = `!fifo_empty & ((count + inflight) < 2 | ((count + inflight) == 2 & pop))`; combinational from registered state, `fifo_empty` and `m_axis_tready`. Never asserted while `fifo_empty`=1.
- `inflight` <= `fifo_rd_en`.
- When `inflight`=1, `fifo_rd_data` is captured this cycle: into `buf0` if buffer empty after pop, else into `buf1`.
- On pop with `count`=2: `buf1` shifts to `buf0` same edge (and a simultaneous capture lands in `buf1`).
- `m_axis_tvalid` = (`count` != 0); tdata/tlast come from `buf0`. Head word stable while tvalid & !tready (AXI-S rule).
- `count` next = `count` + `inflight` − `pop`; never exceeds 2 (guaranteed by read gating; assertion in bench).
- `in_frame`: set on pop with tlast=0, cleared on pop with tlast=1. `frame_count` +1 on pop with tlast=1, 16-bit wrap 0xFFFF→0x0000.
- No frame reassembly or length checking; words pass strictly in FIFO order.

## Timing
- Reset (async assert, sync deassert assumed upstream): `count`=0, `inflight`=0, buffers 0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `frame_count`=0, `in_frame`=0; `fifo_rd_en`=0 while `reset_n`=0.
- Latency: `fifo_rd_en` high in cycle N → data valid on `fifo_rd_data` in N+1 → `m_axis_tvalid` high in N+2. First-word latency from `fifo_empty` falling: 2 cycles.
- Throughput: with `tready`=1 continuously and FIFO non-empty, one word per cycle, no bubbles.
- Back-pressure: after `tready` drops, at most 2 words are held (one already in flight lands in `buf1`); `fifo_rd_en` stays low until a pop frees space.
- `fifo_empty` rising with `inflight`=1: the in-flight word is still captured; no further reads.
- Reset mid-frame: buffered and in-flight words discarded; FIFO is reset by the same `reset_n`.

## Test plan
- Single frame 0x11,0x22,0x33(tlast) written, `tready`=1 → tvalid 2 cycles after first `fifo_rd_en`, bytes in order on consecutive cycles, tlast on 0x33, `frame_count`=1, `in_frame`=0 at end.
- 64-byte frame, `tready`=1 → 64 handshakes in 64 consecutive cycles, `fifo_rd_en` high 64 cycles contiguous.
- Same frame, `tready` toggling 1/0 every cycle and random stalls → output byte sequence identical, tdata/tlast stable during stalls, `count`≤2 always, no `fifo_rd_en` while empty.
- `tready`=0 for 20 cycles with FIFO full → exactly 2 reads issued then `fifo_rd_en`=0; on release, data resumes without loss or duplication.
- 65537 single-byte frames (tlast each) → `frame_count` wraps to 0x0001.
- `reset_n` pulsed low mid-frame with 2 words buffered → all outputs 0 immediately, `frame_count`=0; next frame after reset streams correctly.

Source files
------------

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains the FIFO read port into an AXI-Stream master.
// The FIFO block RAM has one cycle of registered read latency. A word read in
// cycle N is captured in cycle N+1 and presented in N+2. A 2-entry skid buffer
// absorbs that latency, so back-pressure on m_axis_tready never drops a word.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH:0]   fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [15:0]           frame_count,
    output logic                  in_frame
);

    logic [1:0]          count_q, count_d;
    logic                inflight_q;
    logic [DATA_WIDTH:0] buf0_q, buf0_d;
    logic [DATA_WIDTH:0] buf1_q, buf1_d;
    logic [15:0]         frameCount_q, frameCount_d;
    logic                inFrame_q, inFrame_d;

    logic       pop;
    logic [2:0] occupancy;
    logic [1:0] afterPop;

    // The head entry drives the stream. tvalid means at least one word is buffered.
    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = buf0_q[DATA_WIDTH-1:0];
    assign m_axis_tlast  = buf0_q[DATA_WIDTH];
    assign frame_count   = frameCount_q;
    assign in_frame      = inFrame_q;

    assign pop       = m_axis_tvalid & m_axis_tready;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    assign afterPop  = count_q - {1'b0, pop};

    // A read is issued only if the word it returns is sure to find a free slot.
    // A slot counts as free if it is empty now or is emptied by this cycle's pop.
    // The reset_n term keeps the strobe low while reset is held.
    assign fifo_rd_en = reset_n & ~fifo_empty &
                        ((occupancy < 3'd2) | ((occupancy == 3'd2) & pop));

    // Next-state logic for the skid buffer and frame tracking.
    // The shift runs first, so the returning word then lands in the first free slot after the pop.
    always_comb begin
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        count_d      = afterPop + {1'b0, inflight_q};
        frameCount_d = frameCount_q;
        inFrame_d    = inFrame_q;

        if (pop && (count_q == 2'd2)) begin
            buf0_d = buf1_q;
        end

        if (inflight_q) begin
            if (afterPop == 2'd0) begin
                buf0_d = fifo_rd_data;
            end else begin
                buf1_d = fifo_rd_data;
            end
        end

        if (pop) begin
            if (buf0_q[DATA_WIDTH]) begin
                frameCount_d = frameCount_q + 16'd1;
                inFrame_d    = 1'b0;
            end else begin
                inFrame_d    = 1'b1;
            end
        end
    end

    // Register all state. Reset discards both buffered words and any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            frameCount_q <= 16'd0;
            inFrame_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            inflight_q   <= fifo_rd_en;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            frameCount_q <= frameCount_d;
            inFrame_q    <= inFrame_d;
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Testbench for fifo_axis_reader.
// A behavioural FIFO with one-cycle read latency feeds the DUT. Every word
// written to that FIFO is also queued as the expected stream. A negedge
// monitor drives tready and checks every handshake against that queue.
module tb_fifo_axis_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW:0]   fifo_rd_data = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [15:0]   frame_count;
    logic          in_frame;

    logic [DW:0] fifoQ[$];
    logic [DW:0] expQ[$];
    int wrCount = 0;
    int rdDone = 0;
    int popCount = 0;
    int compareCount = 0;
    int mismatchCount = 0;
    int readyMode = 0;
    logic        prevStall = 1'b0;
    logic [DW:0] prevWord = '0;
    logic [15:0] expFrameCount = 16'd0;
    logic        expInFrame = 1'b0;

    fifo_axis_reader #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_count   (frame_count),
        .in_frame      (in_frame)
    );

    initial forever #5 clk = ~clk;

    // FIFO is empty when every written word has been read.
    assign fifo_empty = (wrCount == rdDone);

    // Behavioural FIFO read port. The word appears on fifo_rd_data one cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && fifoQ.size() != 0) begin
            fifo_rd_data <= fifoQ.pop_front();
            rdDone       <= rdDone + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DW:0] word);
        fifoQ.push_back(word);
        expQ.push_back(word);
        wrCount++;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        #1;
        fifoQ.delete();
        expQ.delete();
        wrCount = rdDone;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && (expQ.size() != 0 || m_axis_tvalid); i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: sets tready for the coming edge, then checks the handshake that edge will take.
    always @(negedge clk) begin
        logic [DW:0] expWord;
        case (readyMode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
        #1;
        if (reset_n) begin
            checkOutput("rdWhileEmpty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            checkOutput("countMax", 32'(dut.count_q <= 2'd2), 32'd1);
            if (prevStall) begin
                checkOutput("stallStable", 32'({m_axis_tlast, m_axis_tdata}), 32'(prevWord));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                expWord = (expQ.size() != 0) ? expQ.pop_front() : 9'h1FF;
                checkOutput("streamWord", 32'({m_axis_tlast, m_axis_tdata}), 32'(expWord));
                popCount++;
                if (expWord[DW]) begin
                    expFrameCount = expFrameCount + 16'd1;
                    expInFrame    = 1'b0;
                end else begin
                    expInFrame    = 1'b1;
                end
            end
            prevStall = m_axis_tvalid & ~m_axis_tready;
            prevWord  = {m_axis_tlast, m_axis_tdata};
        end else begin
            prevStall     = 1'b0;
            expFrameCount = 16'd0;
            expInFrame    = 1'b0;
        end
    end

    initial begin
        int popBase;
        int rdBase;

        // Reset values.
        #12;
        checkOutput("rstValid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rstData", 32'(m_axis_tdata), 32'd0);
        checkOutput("rstLast", 32'(m_axis_tlast), 32'd0);
        checkOutput("rstFrames", 32'(frame_count), 32'd0);
        checkOutput("rstInFrame", 32'(in_frame), 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Short frame: latency and back-to-back delivery.
        @(posedge clk);
        #2;
        popBase = popCount;
        applyStimulus(9'h011);
        applyStimulus(9'h022);
        applyStimulus(9'h133);
        #1;
        checkOutput("firstRdEn", 32'(fifo_rd_en), 32'd1);
        checkOutput("lat0Valid", 32'(m_axis_tvalid), 32'd0);
        @(posedge clk);
        #2;
        checkOutput("lat1Valid", 32'(m_axis_tvalid), 32'd0);
        @(posedge clk);
        #2;
        checkOutput("lat2Valid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("lat2Data", 32'(m_axis_tdata), 32'h11);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("shortPops", 32'(popCount - popBase), 32'd3);
        checkOutput("shortFrames", 32'(frame_count), 32'd1);
        checkOutput("shortInFrame", 32'(in_frame), 32'd0);
        waitDrain(20);

        // 64-byte frame at full throughput.
        popBase = popCount;
        rdBase  = rdDone;
        for (int i = 0; i < 64; i++) applyStimulus({(i == 63), 8'(i * 3 + 1)});
        repeat (64) @(posedge clk);
        #2;
        checkOutput("fullRdCount", 32'(rdDone - rdBase), 32'd64);
        @(posedge clk);
        #2;
        checkOutput("fullPops65", 32'(popCount - popBase), 32'd63);
        @(posedge clk);
        #2;
        checkOutput("fullPops66", 32'(popCount - popBase), 32'd64);
        waitDrain(20);

        // Same frame with tready toggling, then with random stalls.
        readyMode = 1;
        for (int i = 0; i < 64; i++) applyStimulus({(i == 63), 8'(i * 3 + 1)});
        waitDrain(400);
        readyMode = 2;
        for (int i = 0; i < 64; i++) applyStimulus({(i == 63), 8'(i * 3 + 1)});
        waitDrain(600);
        checkOutput("stallFrames", 32'(frame_count), 32'(expFrameCount));
        checkOutput("stallFramesAbs", 32'(frame_count), 32'd4);

        // Held back-pressure: only two reads may go out.
        readyMode = 3;
        rdBase = rdDone;
        for (int i = 0; i < 16; i++) applyStimulus({(i == 15), 8'(8'hC0 + i)});
        repeat (20) @(posedge clk);
        #2;
        checkOutput("bpReads", 32'(rdDone - rdBase), 32'd2);
        checkOutput("bpRdEn", 32'(fifo_rd_en), 32'd0);
        checkOutput("bpHead", 32'({m_axis_tlast, m_axis_tdata}), 32'h0C0);
        readyMode = 0;
        waitDrain(100);
        checkOutput("bpFrames", 32'(frame_count), 32'd5);

        // Reset in the middle of a frame with two words buffered.
        popBase = popCount;
        for (int i = 0; i < 12; i++) applyStimulus({(i == 11), 8'(8'hA0 + i)});
        for (int i = 0; i < 20 && (popCount - popBase) < 2; i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("midPops", 32'((popCount - popBase) >= 2), 32'd1);
        readyMode = 3;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("midInFrame", 32'(in_frame), 32'd1);
        checkOutput("midBuffered", 32'(dut.count_q), 32'd2);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("midRstData", 32'(m_axis_tdata), 32'd0);
        checkOutput("midRstLast", 32'(m_axis_tlast), 32'd0);
        checkOutput("midRstFrames", 32'(frame_count), 32'd0);
        checkOutput("midRstInFrame", 32'(in_frame), 32'd0);
        checkOutput("midRstRdEn", 32'(fifo_rd_en), 32'd0);
        applyReset();
        readyMode = 0;
        applyStimulus(9'h055);
        applyStimulus(9'h066);
        applyStimulus(9'h177);
        waitDrain(20);
        checkOutput("postRstFrames", 32'(frame_count), 32'd1);
        checkOutput("postRstInFrame", 32'(in_frame), 32'd0);

        // 65537 single-byte frames: the frame counter wraps to 1.
        applyReset();
        for (int i = 0; i < 65537; i++) applyStimulus({1'b1, 8'(i)});
        waitDrain(70000);
        checkOutput("wrapFrames", 32'(frame_count), 32'h0001);
        checkOutput("wrapModel", 32'(frame_count), 32'(expFrameCount));
        checkOutput("wrapInFrame", 32'(in_frame), 32'(expInFrame));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
